// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} clr_state_t;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_NUM_REGS       = 8;
    localparam int DEF_NUM_READ_PORTS = 2;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Sequential clear engine: walks ptr over every entry, one per cycle,
// while BUSY is high.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  clear,
    output logic                  busy,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] ptr;

    // A clear request seen during SWEEP is dropped, not queued.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= SWEEP;
                        ptr   <= '0;
                    end
                end
                SWEEP: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == SWEEP);
    assign clr_en   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with clear sweep and write-reject flag.
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int ADDR_WIDTH     = $clog2(NUM_REGS),
    parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
    parameter int ZERO_REG       = 0
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [DATA_WIDTH-1:0]                IN,
    input  logic [ADDR_WIDTH-1:0]                INADDRESS,
    input  logic                                 WRITE,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] OUTADDRESS,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] OUT,
    input  logic                                 CLEAR,
    output logic                                 BUSY,
    output logic                                 WRITE_DROPPED
);

    localparam logic [ADDR_WIDTH:0] NREGS = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] store [NUM_REGS];
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_ok;
    logic                  wr_rej;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    reg_file_clear_fsm #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (CLEAR),
        .busy     (BUSY),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Writes to the hardwired zero register are neither stored nor flagged.
    assign wr_ok  = WRITE && !RESET && !BUSY && addr_ok(INADDRESS) && !is_zero_reg(INADDRESS);
    assign wr_rej = WRITE && (BUSY || !addr_ok(INADDRESS));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) store[i] <= '0;
            WRITE_DROPPED <= 1'b0;
        end else begin
            WRITE_DROPPED <= wr_rej;
            if (clr_en) store[clr_addr] <= '0;
            if (wr_ok)  store[INADDRESS] <= IN;
        end
    end

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rdata;

        assign ra = OUTADDRESS[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rdata = '0;
            if (addr_ok(ra) && !is_zero_reg(ra)) rdata = store[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (ra == INADDRESS)) rdata = IN;
`endif
        end

        assign OUT[g*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default 8x8 two-port instance plus a
// 6-entry, single-port, zero-register instance.
module tb_reg_file_mp;

    logic        CLK = 1'b0;
    logic        RESET;

    logic [7:0]  a_in;
    logic [2:0]  a_ia;
    logic        a_we;
    logic [5:0]  a_oa;
    logic [15:0] a_out;
    logic        a_clr, a_busy, a_drop;

    logic [7:0]  b_in;
    logic [2:0]  b_ia;
    logic        b_we;
    logic [2:0]  b_oa;
    logic [7:0]  b_out;
    logic        b_clr, b_busy, b_drop;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    reg_file_mp u_a (
        .CLK(CLK), .RESET(RESET), .IN(a_in), .INADDRESS(a_ia), .WRITE(a_we),
        .OUTADDRESS(a_oa), .OUT(a_out), .CLEAR(a_clr), .BUSY(a_busy),
        .WRITE_DROPPED(a_drop)
    );

    reg_file_mp #(.NUM_REGS(6), .NUM_READ_PORTS(1), .ZERO_REG(1)) u_b (
        .CLK(CLK), .RESET(RESET), .IN(b_in), .INADDRESS(b_ia), .WRITE(b_we),
        .OUTADDRESS(b_oa), .OUT(b_out), .CLEAR(b_clr), .BUSY(b_busy),
        .WRITE_DROPPED(b_drop)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    endtask

    task automatic a_write(input logic [2:0] ad, input logic [7:0] d);
        a_we = 1'b1; a_ia = ad; a_in = d;
        tick();
        a_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old_v [8];
        logic [2:0] k3, km3;

        RESET = 1'b1;
        a_in = '0; a_ia = '0; a_we = 1'b0; a_oa = '0; a_clr = 1'b0;
        b_in = '0; b_ia = '0; b_we = 1'b0; b_oa = '0; b_clr = 1'b0;
        tick();
        RESET = 1'b0;
        #1;

        // reset state
        push("rst_a_out", 32'h0);   pop_chk(32'(a_out));
        push("rst_a_busy", 32'h0);  pop_chk(32'(a_busy));
        push("rst_a_drop", 32'h0);  pop_chk(32'(a_drop));
        push("rst_b_out", 32'h0);   pop_chk(32'(b_out));
        push("rst_b_busy", 32'h0);  pop_chk(32'(b_busy));

        // write A5 to r3, both ports on r3
        a_oa = {3'd3, 3'd3};
        a_we = 1'b1; a_ia = 3'd3; a_in = 8'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_r3_same_cycle", 32'hA5A5);
`else
        push("byp_r3_same_cycle", 32'h0000);
`endif
        pop_chk(32'(a_out));
        tick();
        a_we = 1'b0;
        push("wr_r3_both_ports", 32'hA5A5); pop_chk(32'(a_out));
        push("wr_r3_drop", 32'h0);           pop_chk(32'(a_drop));

        // r2 <= 3C with port0 on r2, port1 on r3
        a_oa = {3'd3, 3'd2};
        a_we = 1'b1; a_ia = 3'd2; a_in = 8'h3C;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_r2_same_cycle", 32'hA53C);
`else
        push("byp_r2_same_cycle", 32'hA500);
`endif
        pop_chk(32'(a_out));
        tick();
        a_we = 1'b0;
        push("wr_r2_after_edge", 32'hA53C); pop_chk(32'(a_out));

        // zero register on B: write FF to r0, never forwarded or stored
        b_oa = 3'd0;
        b_we = 1'b1; b_ia = 3'd0; b_in = 8'hFF;
        #1;
        push("b_r0_no_bypass", 32'h0); pop_chk(32'(b_out));
        tick();
        b_we = 1'b0;
        push("b_r0_reads_zero", 32'h0); pop_chk(32'(b_out));
        push("b_r0_no_drop", 32'h0);    pop_chk(32'(b_drop));

        // B top valid entry
        b_we = 1'b1; b_ia = 3'd5; b_in = 8'h5A; b_oa = 3'd5;
        tick();
        b_we = 1'b0;
        push("b_r5_write", 32'h5A); pop_chk(32'(b_out));

        // B out-of-range write, twice back to back, then idle
        b_we = 1'b1; b_ia = 3'd7; b_in = 8'h77; b_oa = 3'd7;
        #1;
        push("b_oor_no_bypass", 32'h0); pop_chk(32'(b_out));
        tick();
        push("b_oor_drop1", 32'h1);     pop_chk(32'(b_drop));
        push("b_oor_read7", 32'h0);     pop_chk(32'(b_out));
        b_ia = 3'd6;
        tick();
        b_we = 1'b0;
        push("b_oor_drop2", 32'h1);     pop_chk(32'(b_drop));
        tick();
        push("b_drop_falls", 32'h0);    pop_chk(32'(b_drop));
        b_oa = 3'd5;
        #1;
        push("b_r5_intact", 32'h5A);    pop_chk(32'(b_out));

        // fill A with 1..8
        for (int i = 0; i < 8; i++) begin
            a_write(3'(i), 8'(i + 1));
            old_v[i] = 8'(i + 1);
        end
        a_oa = {3'd7, 3'd0};
        #1;
        push("fill_r7_r0", 32'h0801); pop_chk(32'(a_out));

        // clear edge E also carries an accepted write r7 <= 99
        a_clr = 1'b1; a_we = 1'b1; a_ia = 3'd7; a_in = 8'h99;
        old_v[7] = 8'h99;
        tick();
        a_clr = 1'b0; a_we = 1'b0;

        for (int k = 0; k < 8; k++) begin
            k3  = 3'(k);
            km3 = (k == 0) ? 3'd0 : 3'(k - 1);
            a_oa = {km3, k3};
            #1;
            push($sformatf("sweep_busy_%0d", k), 32'h1); pop_chk(32'(a_busy));
            push($sformatf("sweep_read_%0d", k),
                 {16'h0, (k == 0) ? old_v[0] : 8'h00, old_v[k]});
            pop_chk(32'(a_out));
            a_we  = (k == 2);
            a_ia  = 3'd7;
            a_in  = 8'hEE;
            a_clr = (k == 5);
            tick();
            a_we  = 1'b0;
            a_clr = 1'b0;
            if (k == 2) begin
                push("busy_write_drop", 32'h1); pop_chk(32'(a_drop));
            end
            if (k == 3) begin
                push("busy_drop_one_cycle", 32'h0); pop_chk(32'(a_drop));
            end
        end
        push("sweep_done_busy", 32'h0); pop_chk(32'(a_busy));
        a_oa = {3'd7, 3'd3};
        #1;
        push("sweep_all_zero", 32'h0);  pop_chk(32'(a_out));
        a_write(3'd7, 8'h77);
        push("post_sweep_write", 32'h7700); pop_chk(32'(a_out));
        push("post_sweep_drop", 32'h0);     pop_chk(32'(a_drop));

        // reset on the third sweep edge aborts the sweep
        a_write(3'd5, 8'h55);
        a_write(3'd6, 8'h66);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        tick();
        tick();
        push("mid_sweep_busy", 32'h1); pop_chk(32'(a_busy));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        push("rst_abort_busy", 32'h0); pop_chk(32'(a_busy));
        a_oa = {3'd6, 3'd5};
        #1;
        push("rst_abort_regs", 32'h0); pop_chk(32'(a_out));
        a_oa = {3'd4, 3'd7};
        a_write(3'd4, 8'h44);
        push("rst_abort_write", 32'h4400); pop_chk(32'(a_out));
        push("rst_abort_drop", 32'h0);     pop_chk(32'(a_drop));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file: the successor to the fixed 8×8-bit, two-read-port register file. It adds configurable width, depth and read-port count, an optional hardwired-zero register, and a sequential clear engine that zeroes the file one entry per cycle while reporting BUSY. It sits in the single-cycle datapath between the instruction decoder (addresses) and the ALU (operands and result writeback).

## Interface
- DATA_WIDTH, 8, bits per register
- NUM_REGS, 8, number of registers (≥2; need not be a power of two)
- ADDR_WIDTH, $clog2(NUM_REGS), address width
- NUM_READ_PORTS, 2, number of independent read ports (1–4)
- ZERO_REG, 0, when 1 register 0 reads as zero and ignores writes

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IN  in  DATA_WIDTH  write data
- INADDRESS  in  ADDR_WIDTH  write address
- WRITE  in  1  write enable
- OUTADDRESS  in  NUM_READ_PORTS*ADDR_WIDTH  read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- OUT  out  NUM_READ_PORTS*DATA_WIDTH  read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- CLEAR  in  1  request sequential clear of all registers
- BUSY  out  1  clear sweep in progress
- WRITE_DROPPED  out  1  registered one-cycle pulse: a write was rejected

## Operation
- Reads are combinational: OUT[i] = store[OUTADDRESS[i]]. No modelled delays.
- Reads with address ≥ NUM_REGS return 0. With ZERO_REG=1, address 0 returns 0.
- Write: on a rising edge with WRITE=1, RESET=0 and BUSY=0, store[INADDRESS] <= IN.
- A write is rejected (store unchanged; WRITE_DROPPED=1 on the following cycle) when BUSY=1 or INADDRESS ≥ NUM_REGS. A write to register 0 with ZERO_REG=1 is silently ignored and does not pulse WRITE_DROPPED.
- Clear FSM states: IDLE, SWEEP. Pointer ptr is ADDR_WIDTH bits wide.
  - IDLE: on an edge with CLEAR=1, go to SWEEP with ptr=0. A WRITE sampled on the same edge is accepted, because BUSY is still 0.
  - SWEEP: on each edge, store[ptr] <= 0 and ptr++. On the edge where ptr==NUM_REGS-1, clear that entry and return to IDLE.
  - CLEAR asserted while in SWEEP is ignored; a new sweep is not queued.
- BUSY = (state==SWEEP).
- Reads during SWEEP return current contents: already-swept entries read 0, the rest read old data.
- RESET has priority over everything. On the edge: all registers = 0, state = IDLE, ptr = 0, WRITE_DROPPED = 0. RESET mid-sweep aborts the sweep.
- Reset values: BUSY=0, WRITE_DROPPED=0, and OUT=0 for every port.

## Timing
- Write latency: data is visible on OUT the cycle after the capturing edge (combinationally after that edge).
- Clear: CLEAR is sampled at edge E. BUSY is high from E until edge E+NUM_REGS. Writes are accepted again at edge E+NUM_REGS+1.
- WRITE_DROPPED is asserted for exactly one cycle after each rejected edge. Back-to-back rejects keep it high.
- Read-address-to-OUT is a purely combinational path with no cycle latency.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding. When WRITE=1, the write will be accepted, and OUTADDRESS[i]==INADDRESS, OUT[i]=IN in the same cycle.
  - No forwarding for rejected or ignored writes, including register 0 with ZERO_REG=1.
- REGFILE_BYPASS_EN undefined: OUT[i] shows the old contents until the write edge.

## Structure
- Shared package reg_file_pkg holds:
  - clear FSM state typedef (IDLE, SWEEP)
  - default width/depth/port constants used by the datapath
- Sub-module reg_file_clear_fsm: owns state, ptr and BUSY, and outputs a clear-enable plus clear address to the storage array.
- Storage, read muxes, write-reject logic and the bypass live in reg_file_mp.

## Test plan
- Reset, then write 8'hA5 to r3. Set OUTADDRESS={3,3} → both ports read 8'hA5 next cycle, WRITE_DROPPED=0.
- ZERO_REG=1: write 8'hFF to r0 → reads 0, WRITE_DROPPED stays 0.
- Fill r0–r7 with 1..8, then pulse CLEAR → BUSY high for 8 cycles; entries read 0 in order r0..r7. A write during BUSY is rejected and WRITE_DROPPED pulses for one cycle.
- Assert RESET on the 3rd sweep cycle → BUSY=0 next cycle, all registers 0, a write on the following edge is accepted.
- NUM_REGS=6: write to address 7 → WRITE_DROPPED=1, and reading address 7 returns 0.
- With REGFILE_BYPASS_EN: WRITE=1, INADDRESS=2, IN=8'h3C, OUTADDRESS[0]=2 → OUT[0]=8'h3C in the same cycle. Without the macro, OUT[0] shows the old value until the write edge.
